// File: rtl/out_byte_uart_tx_pkg.sv
// Shared definitions for the debug-byte UART transmitter: FSM encoding and
// serial frame geometry.
package out_byte_uart_tx_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

endpackage : out_byte_uart_tx_pkg

// File: rtl/out_byte_uart_tx_sync_fifo.sv
// Single-clock FIFO with a show-ahead head entry: dout always presents the
// oldest byte, so a consumer latches it on the same edge it pops.
// Pop must only be asserted when the FIFO is not empty.
module sync_fifo
   import out_byte_uart_tx_pkg::*;
#(
   parameter int FIFO_AW = 4
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 push,
   input  logic                 pop,
   input  logic [DATA_BITS-1:0] din,
   output logic [DATA_BITS-1:0] dout,
   output logic [FIFO_AW:0]     level,
   output logic                 full,
   output logic                 empty
);

   localparam int DEPTH = 2 ** FIFO_AW;
   localparam int LVL_W = FIFO_AW + 1;

   logic [DATA_BITS-1:0] r_mem [DEPTH];
   logic [FIFO_AW-1:0]   r_wr_ptr;
   logic [FIFO_AW-1:0]   r_rd_ptr;
   logic [LVL_W-1:0]     r_level;

   // Storage array; no reset, contents are only meaningful below the level.
   always_ff @(posedge clk) begin
      if (push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointers wrap modulo depth; level tracks occupancy including push+pop.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign level = r_level;
   assign full  = (r_level == LVL_W'(DEPTH));
   assign empty = (r_level == '0);

endmodule : sync_fifo

// File: rtl/out_byte_uart_tx.sv
// Debug byte port to asynchronous serial bridge. Bytes strobed in by the CPU
// are queued and sent LSB first as 8N1/8N2 on txd. The port cannot stall the
// CPU, so bytes arriving at a full queue are dropped and flagged in a sticky
// overflow bit.
module out_byte_uart_tx
   import out_byte_uart_tx_pkg::*;
#(
   parameter int CLK_DIV   = 16,
   parameter int FIFO_AW   = 4,
   parameter int STOP_BITS = 1
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [7:0]         in_byte,
   input  logic               in_valid,
   input  logic               ovf_clear,
   output logic               txd,
   output logic               tx_busy,
   output logic [FIFO_AW:0]   fifo_level,
   output logic               fifo_full,
   output logic               overflow
);

   localparam int BAUD_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
   localparam logic [2:0]        LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0]        LAST_STOP = 3'(STOP_BITS - 1);

   uart_state_t          r_state;
   uart_state_t          w_state_nxt;
   logic [BAUD_W-1:0]    r_baud;
   logic [BAUD_W-1:0]    w_baud_nxt;
   logic [2:0]           r_bit_idx;
   logic [2:0]           w_bit_idx_nxt;
   logic [7:0]           r_shift;
   logic [7:0]           w_shift_nxt;
   logic                 r_txd;
   logic                 w_txd_nxt;
   logic                 r_ovf;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_drop;
   logic [7:0]           w_fifo_dout;
   logic                 w_fifo_full;
   logic                 w_fifo_empty;

   // A byte arriving at a full queue still fits if the head leaves this cycle.
   assign w_push = in_valid && (!w_fifo_full || w_pop);
   assign w_drop = in_valid && !w_push;

   sync_fifo #(
      .FIFO_AW (FIFO_AW)
   ) u_fifo (
      .clk    (clk),
      .resetn (resetn),
      .push   (w_push),
      .pop    (w_pop),
      .din    (in_byte),
      .dout   (w_fifo_dout),
      .level  (fifo_level),
      .full   (w_fifo_full),
      .empty  (w_fifo_empty)
   );

   // Frame sequencing: next state, baud/bit counters, shifter and next txd.
   always_comb begin
      w_state_nxt   = r_state;
      w_baud_nxt    = r_baud;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_txd_nxt     = r_txd;
      w_pop         = 1'b0;

      case (r_state)
         ST_IDLE: begin
            w_txd_nxt = 1'b1;
            if (!w_fifo_empty) begin
               w_pop       = 1'b1;
               w_shift_nxt = w_fifo_dout;
               w_baud_nxt  = BAUD_LAST;
               w_txd_nxt   = 1'b0;
               w_state_nxt = ST_START;
            end
         end

         ST_START: begin
            if (r_baud == '0) begin
               w_baud_nxt    = BAUD_LAST;
               w_bit_idx_nxt = 3'd0;
               w_txd_nxt     = r_shift[0];
               w_state_nxt   = ST_DATA;
            end else begin
               w_baud_nxt = r_baud - 1'b1;
            end
         end

         ST_DATA: begin
            if (r_baud == '0) begin
               w_baud_nxt = BAUD_LAST;
               if (r_bit_idx == LAST_DATA) begin
                  w_bit_idx_nxt = 3'd0;
                  w_txd_nxt     = 1'b1;
                  w_state_nxt   = ST_STOP;
               end else begin
                  w_shift_nxt   = {1'b0, r_shift[7:1]};
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
                  w_txd_nxt     = r_shift[1];
               end
            end else begin
               w_baud_nxt = r_baud - 1'b1;
            end
         end

         ST_STOP: begin
            // bit_idx doubles as the stop-bit counter here.
            if (r_baud == '0) begin
               if (r_bit_idx == LAST_STOP) begin
                  w_bit_idx_nxt = 3'd0;
                  if (!w_fifo_empty) begin
                     w_pop       = 1'b1;
                     w_shift_nxt = w_fifo_dout;
                     w_baud_nxt  = BAUD_LAST;
                     w_txd_nxt   = 1'b0;
                     w_state_nxt = ST_START;
                  end else begin
                     w_txd_nxt   = 1'b1;
                     w_state_nxt = ST_IDLE;
                  end
               end else begin
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
                  w_baud_nxt    = BAUD_LAST;
               end
            end else begin
               w_baud_nxt = r_baud - 1'b1;
            end
         end

         default: begin
            w_txd_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Control registers; reset abandons any frame and returns the line to idle.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state   <= ST_IDLE;
         r_baud    <= '0;
         r_bit_idx <= 3'd0;
         r_txd     <= 1'b1;
      end else begin
         r_state   <= w_state_nxt;
         r_baud    <= w_baud_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_txd     <= w_txd_nxt;
      end
   end

   // Shift register holds payload only, so it needs no reset.
   always_ff @(posedge clk) begin
      r_shift <= w_shift_nxt;
   end

   // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (ovf_clear) begin
         r_ovf <= 1'b0;
      end
   end

   assign txd       = r_txd;
   assign tx_busy   = (r_state != ST_IDLE);
   assign fifo_full = w_fifo_full;
   assign overflow  = r_ovf;

endmodule : out_byte_uart_tx
